// File: rtl/downstream_vc_tracker.sv
// -----------------------------------------------------------------------------
// downstream_vc_tracker
//
// Purpose:
//   Per-output-port tracker of downstream virtual-channel ownership and credits.
//   Each downstream VC v (v = port*VC_NUM + vc) owns a small FSM
//   {IDLE, ACTIVE, DRAINING} and a credit counter that starts at BUFFER_SIZE.
//   A VC reads as idle only when no packet owns it and every credit is home,
//   so the VC allocator can safely reclaim it.
//
// Ports:
//   clk                  clock
//   rst                  synchronous, active-high reset
//   vc_alloc_i           [VC_TOTAL]           grant of downstream VC v this cycle
//   flit_sent_i          [PORT_NUM]           a flit leaves output port p
//   flit_sent_vc_i       [PORT_NUM][VC_SIZE]  downstream VC of that flit
//   flit_sent_tail_i     [PORT_NUM]           that flit is a tail (or head-tail)
//   credit_valid_i       [PORT_NUM]           one credit returned on port p
//   credit_vc_i          [PORT_NUM][VC_SIZE]  VC of the returned credit
//   idle_downstream_vc_o [VC_TOTAL]           VC v is IDLE
//   has_credit_o         [VC_TOTAL]           credit counter of VC v is non-zero
//   error_o                                   sticky protocol error
//   state_dbg_o          [2*VC_TOTAL]         FSM state of VC v at bits [2v+1:2v]
//                                             (0 = IDLE, 1 = ACTIVE, 2 = DRAINING)
//
// Handshake: all inputs are single-cycle event pulses sampled on the rising
// edge; there is no back-pressure. Outputs are decoded from registers, so any
// input event is visible one cycle later.
//
// Configuration macro: VC_TRACKER_CHECK_EN
//   Defined   - illegal events set error_o until rst and report with $error.
//   Undefined - no checking logic, error_o tied to 0.
//   Counter saturation is present in both builds.
// -----------------------------------------------------------------------------
module downstream_vc_tracker #(
  parameter int  VC_TOTAL    = 10,
  parameter int  PORT_NUM    = 5,
  parameter int  VC_NUM      = 2,
  parameter int  BUFFER_SIZE = 8,
  localparam int VC_SIZE     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int CNT_W       = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [VC_TOTAL-1:0]              vc_alloc_i,
  input  logic [PORT_NUM-1:0]              flit_sent_i,
  input  logic [PORT_NUM-1:0][VC_SIZE-1:0] flit_sent_vc_i,
  input  logic [PORT_NUM-1:0]              flit_sent_tail_i,
  input  logic [PORT_NUM-1:0]              credit_valid_i,
  input  logic [PORT_NUM-1:0][VC_SIZE-1:0] credit_vc_i,
  output logic [VC_TOTAL-1:0]              idle_downstream_vc_o,
  output logic [VC_TOTAL-1:0]              has_credit_o,
  output logic                             error_o,
  output logic [2*VC_TOTAL-1:0]            state_dbg_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_DRAINING = 2'd2
  } vc_state_e;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_SIZE);

  logic [VC_TOTAL-1:0] illegal_ev;

  for (genvar v = 0; v < VC_TOTAL; v++) begin : g_vc
    localparam int                P  = v / VC_NUM;
    localparam logic [VC_SIZE-1:0] VC = VC_SIZE'(v % VC_NUM);

    vc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dec, inc, tail;

    assign dec  = flit_sent_i[P] && (flit_sent_vc_i[P] == VC);
    assign inc  = credit_valid_i[P] && (credit_vc_i[P] == VC);
    assign tail = dec && flit_sent_tail_i[P];

    // Counter: simultaneous send and credit cancel; otherwise saturate.
    always_comb begin
      cnt_d = cnt_q;
      if (dec && !inc) begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
      end else if (inc && !dec) begin
        cnt_d = (cnt_q == CNT_FULL) ? CNT_FULL : cnt_q + 1'b1;
      end
    end

    // State transitions look at the post-update counter, so a tail whose
    // credit returns on the same edge releases the VC immediately.
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        ST_IDLE: begin
          if (vc_alloc_i[v]) state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (tail) state_d = (cnt_d == CNT_FULL) ? ST_IDLE : ST_DRAINING;
        end
        ST_DRAINING: begin
          if (cnt_d == CNT_FULL) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= CNT_FULL;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign illegal_ev[v] = (vc_alloc_i[v] && (state_q != ST_IDLE))
                         || (dec && (state_q != ST_ACTIVE))
                         || (dec && (cnt_q == '0))
                         || (inc && (cnt_q == CNT_FULL));

`ifdef VC_TRACKER_CHECK_EN
`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
      if (!rst && illegal_ev[v]) begin
        $error("%0t: downstream_vc_tracker illegal event on VC %0d", $time, v);
      end
    end
`endif
`endif

    assign idle_downstream_vc_o[v] = (state_q == ST_IDLE);
    assign has_credit_o[v]         = (cnt_q != '0);
    assign state_dbg_o[2*v +: 2]   = state_q;
  end

`ifdef VC_TRACKER_CHECK_EN
  logic error_q;

  always_ff @(posedge clk) begin
    if (rst) error_q <= 1'b0;
    else     error_q <= error_q | (|illegal_ev);
  end

  assign error_o = error_q;
`else
  // Illegal events are computed only to keep the per-VC logic uniform;
  // they do not drive anything in this build.
  logic unused_illegal;
  assign unused_illegal = |illegal_ev;
  assign error_o        = 1'b0;
`endif

endmodule

// File: tb/tb_downstream_vc_tracker.sv
module tb_downstream_vc_tracker;

  localparam int VT = 10;
  localparam int PN = 5;
  localparam int VN = 2;
  localparam int BS = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [VT-1:0]   vc_alloc;
  logic [PN-1:0]   flit_sent;
  logic [PN-1:0][0:0] flit_sent_vc;
  logic [PN-1:0]   flit_sent_tail;
  logic [PN-1:0]   credit_valid;
  logic [PN-1:0][0:0] credit_vc;
  logic [VT-1:0]   idle_o;
  logic [VT-1:0]   has_credit_o;
  logic            error_o;
  logic [2*VT-1:0] state_dbg_o;

  int checks = 0;
  int errors = 0;

  downstream_vc_tracker dut (
    .clk                  (clk),
    .rst                  (rst),
    .vc_alloc_i           (vc_alloc),
    .flit_sent_i          (flit_sent),
    .flit_sent_vc_i       (flit_sent_vc),
    .flit_sent_tail_i     (flit_sent_tail),
    .credit_valid_i       (credit_valid),
    .credit_vc_i          (credit_vc),
    .idle_downstream_vc_o (idle_o),
    .has_credit_o         (has_credit_o),
    .error_o              (error_o),
    .state_dbg_o          (state_dbg_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Reference model: a VC is owned by a packet from grant until its tail has
  // left and every credit it consumed is back home.
  bit m_owned [VT];
  bit m_tail  [VT];
  int m_cred  [VT];
  bit m_err;

  task automatic model_reset();
    for (int v = 0; v < VT; v++) begin
      m_owned[v] = 0;
      m_tail[v]  = 0;
      m_cred[v]  = BS;
    end
    m_err = 0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int v = 0; v < VT; v++) begin
      int  p, c;
      bit  d, i, t;
      p = v / VN;
      c = v % VN;
      d = flit_sent[p] && (int'(flit_sent_vc[p]) == c);
      i = credit_valid[p] && (int'(credit_vc[p]) == c);
      t = d && flit_sent_tail[p];
`ifdef VC_TRACKER_CHECK_EN
      if ((vc_alloc[v] && m_owned[v]) || (d && (!m_owned[v] || m_tail[v]))
          || (d && m_cred[v] == 0) || (i && m_cred[v] == BS)) m_err = 1;
`endif
      if (d && !i && m_cred[v] > 0)  m_cred[v] = m_cred[v] - 1;
      if (i && !d && m_cred[v] < BS) m_cred[v] = m_cred[v] + 1;
      if (!m_owned[v]) begin
        if (vc_alloc[v]) begin
          m_owned[v] = 1;
          m_tail[v]  = 0;
        end
      end else if (!m_tail[v]) begin
        if (t) begin
          m_tail[v] = 1;
          if (m_cred[v] == BS) m_owned[v] = 0;
        end
      end else if (m_cred[v] == BS) begin
        m_owned[v] = 0;
      end
    end
  endtask

  // scoreboard: expected output words queued per check, popped on compare
  logic [2*VT+2*VT:0] exp_q[$];

  task automatic check_all(input string tag);
    logic [VT-1:0]   e_idle, e_cred;
    logic [2*VT-1:0] e_st;
    logic [2*VT+2*VT:0] e;
    for (int v = 0; v < VT; v++) begin
      e_idle[v] = !m_owned[v];
      e_cred[v] = (m_cred[v] != 0);
      e_st[2*v +: 2] = !m_owned[v] ? 2'd0 : (m_tail[v] ? 2'd2 : 2'd1);
    end
    exp_q.push_back({m_err, e_st, e_cred, e_idle});
    e = exp_q.pop_front();
    checks += 4;
    assert (idle_o === e[VT-1:0]) else begin
      errors++;
      $error("FAIL %s idle: got %h expected %h", tag, idle_o, e[VT-1:0]);
    end
    assert (has_credit_o === e[2*VT-1:VT]) else begin
      errors++;
      $error("FAIL %s has_credit: got %h expected %h", tag, has_credit_o, e[2*VT-1:VT]);
    end
    assert (state_dbg_o === e[4*VT-1:2*VT]) else begin
      errors++;
      $error("FAIL %s state: got %h expected %h", tag, state_dbg_o, e[4*VT-1:2*VT]);
    end
    assert (error_o === e[4*VT]) else begin
      errors++;
      $error("FAIL %s error: got %b expected %b", tag, error_o, e[4*VT]);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    vc_alloc       = '0;
    flit_sent      = '0;
    flit_sent_vc   = '0;
    flit_sent_tail = '0;
    credit_valid   = '0;
    credit_vc      = '0;
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic send(input int p, input int c, input bit t);
    flit_sent[p]      = 1'b1;
    flit_sent_vc[p]   = 1'(c);
    flit_sent_tail[p] = t;
  endtask

  task automatic credit(input int p, input int c);
    credit_valid[p] = 1'b1;
    credit_vc[p]    = 1'(c);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; tick(tag);
    rst = 1'b1; tick(tag);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // reset state
    do_reset("reset");
    assert (idle_o === 10'h3FF && has_credit_o === 10'h3FF) else begin
      errors++;
      $error("FAIL reset_const: got idle %h cred %h expected 3ff 3ff", idle_o, has_credit_o);
    end
    checks++;

    // single-flit packet on v=2 (port 1, vc 0)
    vc_alloc = 10'h004;  tick("sf_alloc");
    send(1, 0, 1'b1);    tick("sf_tail");
    credit(1, 0);        tick("sf_credit");

    // credit exhaustion on v=9 (port 4, vc 1)
    vc_alloc[9] = 1'b1;  tick("ex_alloc");
    for (int k = 0; k < 8; k++) begin
      send(4, 1, 1'b0);  tick("ex_send");
    end
    credit(4, 1);        tick("ex_credit1");
    send(4, 1, 1'b1);    tick("ex_tail");
    for (int k = 0; k < 8; k++) begin
      credit(4, 1);      tick("ex_drain");
    end

    // simultaneous send + credit on v=0 with full counter and tail
    vc_alloc[0] = 1'b1;  tick("sim_alloc");
    send(0, 0, 1'b1);
    credit(0, 0);        tick("sim_tail_credit");

    // all ports busy in the same cycle, alternating vc per port
    vc_alloc = 10'b01_10_01_10_01; tick("all_alloc");
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < PN; p++) send(p, p % 2, 1'b0);
      tick("all_send");
    end
    for (int p = 0; p < PN; p++) begin
      send(p, p % 2, 1'b0);
      credit(p, p % 2);
    end
    tick("all_send_credit");
    for (int p = 0; p < PN; p++) credit(p, p % 2);
    tick("all_credit");

    // credit on v=3 at a full counter: flagged only in the checking build
    do_reset("pre_err_reset");
    credit(1, 1);        tick("err_credit");
    credit(1, 1);        tick("err_hold");
    do_reset("err_reset");

`ifndef VC_TRACKER_CHECK_EN
    // send on an idle VC with an empty counter: counter must floor at zero
    for (int k = 0; k < 9; k++) begin
      send(2, 1, 1'b0);  tick("sat_floor");
    end
    do_reset("sat_reset");
`endif

    // randomized legal traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int v = 0; v < VT; v++)
        if (!m_owned[v] && $urandom_range(0, 3) == 0) vc_alloc[v] = 1'b1;
      for (int p = 0; p < PN; p++) begin
        int c, v;
        c = $urandom_range(0, 1);
        v = p * VN + c;
        if (m_owned[v] && !m_tail[v] && m_cred[v] > 0 && $urandom_range(0, 1) == 1)
          send(p, c, ($urandom_range(0, 3) == 0));
        c = $urandom_range(0, 1);
        v = p * VN + c;
        if (m_cred[v] < BS && $urandom_range(0, 2) != 0) credit(p, c);
      end
      if (cyc == 250) rst = 1'b1;
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
